// File: rtl/s2_demux.sv
// Registered 1-to-4 demultiplexer: steers one input word into one of four
// holding registers chosen by the A1/B1/A0/B0 decode, with per-channel valid/ack.
module s2_demux #(
   parameter int size = 5
) (
   input  logic            clk,
   input  logic            CLR,
   input  logic [size-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic            A1,
   input  logic            B1,
   input  logic            A0,
   input  logic            B0,
   output logic [size-1:0] Q00,
   output logic [size-1:0] Q01,
   output logic [size-1:0] Q10,
   output logic [size-1:0] Q11,
   output logic [3:0]      q_valid,
   input  logic [3:0]      q_ack,
   output logic [7:0]      accept_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

   chan_state_t     state     [4];
   chan_state_t     state_nxt [4];
   logic [1:0]      sel;
   logic            accept;
   logic [size-1:0] q [4];

   assign sel       = {A1 | B1, A0 & B0};
   // A full channel can still take a word on the edge its consumer drains it.
   assign din_ready = ~q_valid[sel] | q_ack[sel];
   assign accept    = din_valid & din_ready;

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < 4; i++) state[i] <= EMPTY;
      end else begin
         for (int i = 0; i < 4; i++) state[i] <= state_nxt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_nxt[i] = state[i];
         case (state[i])
            EMPTY: if (accept && sel == 2'(i)) state_nxt[i] = FULL;
            FULL: begin
               if (accept && sel == 2'(i)) state_nxt[i] = FULL;
               else if (q_ack[i])           state_nxt[i] = EMPTY;
            end
            default: state_nxt[i] = EMPTY;
         endcase
      end
   end

   always_comb begin
      q_valid = '0;
      for (int i = 0; i < 4; i++) q_valid[i] = (state[i] == FULL);
   end

   // Holding registers keep stale data after consumption; only q_valid qualifies them.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < 4; i++) q[i] <= '0;
      end else if (accept) begin
         q[sel] <= din;
      end
   end

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR)         accept_cnt <= 8'd0;
      else if (accept) accept_cnt <= accept_cnt + 8'd1;
   end

   assign Q00 = q[0];
   assign Q01 = q[1];
   assign Q10 = q[2];
   assign Q11 = q[3];

endmodule
